// File: rtl/dmem_req_sched.sv
// Data-memory request scheduler between the coherence bus and main memory.
// Requests enter an in-order issue queue (stores may arrive before their data),
// the head is issued one command per cycle, and outstanding loads are tracked
// by memory tag so responses may return out of order, tagged with the bus ptr.
// Optional: define DMEM_LD_FWD_EN to forward ready store data to a matching
// arriving load through a one-entry forward register.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_*                        bus request (valid/ready, store flag, addr, data, ptr)
//   wdat_*                       late store data (valid, addr, data)
//   rsp_*                        load response to bus (valid, ptr, data)
//   mem_cmd_o/addr_o/data_o      command to memory (0=NONE, 1=LOAD, 2=STORE)
//   mem_resp_i                   nonzero = command accepted, value = tag
//   mem_tag_i/mem_data_i         returning load data and its tag (0 = none)
module dmem_req_sched #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned PTR_W     = 3,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned ISS_DEPTH = 8,
    parameter int unsigned RSP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld_i,
    output logic              req_rdy_o,
    input  logic              req_st_i,
    input  logic              req_dat_rdy_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [PTR_W-1:0]  req_ptr_i,
    input  logic              wdat_vld_i,
    input  logic [ADDR_W-1:0] wdat_addr_i,
    input  logic [DATA_W-1:0] wdat_data_i,
    output logic              rsp_vld_o,
    output logic [PTR_W-1:0]  rsp_ptr_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [1:0]        mem_cmd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [TAG_W-1:0]  mem_resp_i,
    input  logic [TAG_W-1:0]  mem_tag_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int unsigned ISS_AW = (ISS_DEPTH > 1) ? $clog2(ISS_DEPTH) : 1;
    localparam int unsigned RSP_IW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [1:0]  CMD_NONE  = 2'd0;
    localparam logic [1:0]  CMD_LOAD  = 2'd1;
    localparam logic [1:0]  CMD_STORE = 2'd2;

    // Issue queue storage; head/tail carry an extra wrap bit in the MSB.
    logic              iq_vld  [ISS_DEPTH];
    logic              iq_rdy  [ISS_DEPTH];
    logic              iq_st   [ISS_DEPTH];
    logic [ADDR_W-1:0] iq_addr [ISS_DEPTH];
    logic [DATA_W-1:0] iq_data [ISS_DEPTH];
    logic [PTR_W-1:0]  iq_ptr  [ISS_DEPTH];
    logic [ISS_AW:0]   head_q;
    logic [ISS_AW:0]   tail_q;

    // Outstanding-load tracker.
    logic              trk_vld [RSP_DEPTH];
    logic [TAG_W-1:0]  trk_tag [RSP_DEPTH];
    logic [PTR_W-1:0]  trk_ptr [RSP_DEPTH];

    logic [ISS_AW-1:0] head_idx;
    logic [ISS_AW-1:0] tail_idx;
    logic              iq_full;
    logic              head_accept;
    logic              enq;
    logic [ADDR_W-1:0] req_key;
    logic [ADDR_W-1:0] wdat_key;
    logic              trk_full;
    logic              trk_free_found;
    logic [RSP_IW-1:0] trk_free_idx;
    logic              trk_hit;
    logic [RSP_IW-1:0] trk_hit_idx;
    logic [PTR_W-1:0]  trk_hit_ptr;
    logic              fwd_take;
    logic              fwd_vld;
    logic [PTR_W-1:0]  fwd_ptr;
    logic [DATA_W-1:0] fwd_data;

    assign head_idx = head_q[ISS_AW-1:0];
    assign tail_idx = tail_q[ISS_AW-1:0];
    assign iq_full  = (head_idx == tail_idx) && (head_q[ISS_AW] != tail_q[ISS_AW]);
    // Block addresses: the low 3 bits never take part in storage or matching.
    assign req_key  = req_addr_i & ~ADDR_W'(7);
    assign wdat_key = wdat_addr_i & ~ADDR_W'(7);

    // Tracker scan: fullness, lowest free slot, and tag match.
    always_comb begin
        trk_full       = 1'b1;
        trk_free_found = 1'b0;
        trk_free_idx   = '0;
        trk_hit        = 1'b0;
        trk_hit_idx    = '0;
        trk_hit_ptr    = '0;
        for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
            if (!trk_vld[i]) begin
                trk_full = 1'b0;
                if (!trk_free_found) begin
                    trk_free_found = 1'b1;
                    trk_free_idx   = RSP_IW'(i);
                end
            end
            if (trk_vld[i] && (mem_tag_i != '0) && (trk_tag[i] == mem_tag_i) && !trk_hit) begin
                trk_hit     = 1'b1;
                trk_hit_idx = RSP_IW'(i);
                trk_hit_ptr = trk_ptr[i];
            end
        end
    end

    // Head command; loads additionally need a free tracker slot.
    always_comb begin
        mem_cmd_o  = CMD_NONE;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (!rst && iq_vld[head_idx] && iq_rdy[head_idx]) begin
            if (iq_st[head_idx]) begin
                mem_cmd_o  = CMD_STORE;
                mem_addr_o = iq_addr[head_idx];
                mem_data_o = iq_data[head_idx];
            end else if (!trk_full) begin
                mem_cmd_o  = CMD_LOAD;
                mem_addr_o = iq_addr[head_idx];
            end
        end
    end

    assign head_accept = (mem_cmd_o != CMD_NONE) && (mem_resp_i != '0);
    assign req_rdy_o   = rst | ((~iq_full | head_accept) & ~fwd_vld);
    assign enq         = req_vld_i & req_rdy_o & ~fwd_take;

    // Tracker match wins the response port; forwarded data waits for a free cycle.
    always_comb begin
        rsp_vld_o  = 1'b0;
        rsp_ptr_o  = '0;
        rsp_data_o = '0;
        if (!rst) begin
            if (trk_hit) begin
                rsp_vld_o  = 1'b1;
                rsp_ptr_o  = trk_hit_ptr;
                rsp_data_o = mem_data_i;
            end else if (fwd_vld) begin
                rsp_vld_o  = 1'b1;
                rsp_ptr_o  = fwd_ptr;
                rsp_data_o = fwd_data;
            end
        end
    end

`ifdef DMEM_LD_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_src_data;

    // Walk oldest to youngest so the youngest matching store decides.
    always_comb begin
        fwd_hit      = 1'b0;
        fwd_src_data = '0;
        for (int unsigned k = 0; k < ISS_DEPTH; k++) begin
            if (iq_vld[ISS_AW'(head_idx + ISS_AW'(k))] && iq_st[ISS_AW'(head_idx + ISS_AW'(k))] &&
                (iq_addr[ISS_AW'(head_idx + ISS_AW'(k))] == req_key)) begin
                fwd_hit      = iq_rdy[ISS_AW'(head_idx + ISS_AW'(k))];
                fwd_src_data = iq_data[ISS_AW'(head_idx + ISS_AW'(k))];
            end
        end
    end

    assign fwd_take = req_vld_i & req_rdy_o & ~req_st_i & fwd_hit;

    // One-entry forward register, released on the first cycle without a tag match.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_vld  <= 1'b0;
            fwd_ptr  <= '0;
            fwd_data <= '0;
        end else if (fwd_take) begin
            fwd_vld  <= 1'b1;
            fwd_ptr  <= req_ptr_i;
            fwd_data <= fwd_src_data;
        end else if (fwd_vld && !trk_hit) begin
            fwd_vld  <= 1'b0;
        end
    end
`else
    assign fwd_take = 1'b0;
    assign fwd_vld  = 1'b0;
    assign fwd_ptr  = '0;
    assign fwd_data = '0;
`endif

    // Queue and tracker state; later assignments override earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int unsigned i = 0; i < ISS_DEPTH; i++) iq_vld[i] <= 1'b0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) trk_vld[i] <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ISS_DEPTH; i++) begin
                if (wdat_vld_i && iq_vld[i] && !iq_rdy[i] && iq_st[i] && (iq_addr[i] == wdat_key)) begin
                    iq_rdy[i]  <= 1'b1;
                    iq_data[i] <= wdat_data_i;
                end
            end
            if (trk_hit) trk_vld[trk_hit_idx] <= 1'b0;
            if (head_accept) begin
                iq_vld[head_idx] <= 1'b0;
                head_q           <= head_q + (ISS_AW+1)'(1);
                if (!iq_st[head_idx]) begin
                    trk_vld[trk_free_idx] <= 1'b1;
                    trk_tag[trk_free_idx] <= mem_resp_i;
                    trk_ptr[trk_free_idx] <= iq_ptr[head_idx];
                end
            end
            if (enq) begin
                iq_vld[tail_idx]  <= 1'b1;
                iq_rdy[tail_idx]  <= ~req_st_i | req_dat_rdy_i;
                iq_st[tail_idx]   <= req_st_i;
                iq_addr[tail_idx] <= req_key;
                iq_data[tail_idx] <= req_data_i;
                iq_ptr[tail_idx]  <= req_ptr_i;
                tail_q            <= tail_q + (ISS_AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_req_sched.sv
// Self-checking bench for dmem_req_sched: scenario tasks with scoreboards of
// expected memory commands and bus responses.
module tb_dmem_req_sched;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned TAG_W  = 4;
    localparam logic [1:0]  C_NONE  = 2'd0;
    localparam logic [1:0]  C_LOAD  = 2'd1;
    localparam logic [1:0]  C_STORE = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_vld;
    logic              req_rdy;
    logic              req_st;
    logic              req_dat_rdy;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [PTR_W-1:0]  req_ptr;
    logic              wdat_vld;
    logic [ADDR_W-1:0] wdat_addr;
    logic [DATA_W-1:0] wdat_data;
    logic              rsp_vld;
    logic [PTR_W-1:0]  rsp_ptr;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [TAG_W-1:0]  mem_resp;
    logic [TAG_W-1:0]  mem_tag;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct packed {
        logic [PTR_W-1:0]  ptr;
        logic [DATA_W-1:0] data;
    } rsp_t;
    typedef struct packed {
        logic [1:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    rsp_t rsp_q[$];
    cmd_t cmd_q[$];
    rsp_t er;
    cmd_t ec;
    int   total = 0;
    int   bad   = 0;

    dmem_req_sched dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld_i     (req_vld),
        .req_rdy_o     (req_rdy),
        .req_st_i      (req_st),
        .req_dat_rdy_i (req_dat_rdy),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .req_ptr_i     (req_ptr),
        .wdat_vld_i    (wdat_vld),
        .wdat_addr_i   (wdat_addr),
        .wdat_data_i   (wdat_data),
        .rsp_vld_o     (rsp_vld),
        .rsp_ptr_o     (rsp_ptr),
        .rsp_data_o    (rsp_data),
        .mem_cmd_o     (mem_cmd),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_data),
        .mem_resp_i    (mem_resp),
        .mem_tag_i     (mem_tag),
        .mem_data_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        req_vld = 1'b0; req_st = 1'b0; req_dat_rdy = 1'b0;
        req_addr = '0; req_data = '0; req_ptr = '0;
        wdat_vld = 1'b0; wdat_addr = '0; wdat_data = '0;
        mem_resp = '0; mem_tag = '0; mem_rdata = '0;
    endtask

    // Leaves the bench at a negedge with rst low and inputs idle.
    task automatic do_reset();
        @(negedge clk); drive_idle(); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        rsp_q.delete();
        cmd_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL rst_req_rdy: got %b want 1", req_rdy); end
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL rst_rsp_vld: got %b want 0", rsp_vld); end
        total++; if (rsp_ptr !== '0) begin bad++; $display("FAIL rst_rsp_ptr: got %0d want 0", rsp_ptr); end
        total++; if (rsp_data !== '0) begin bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        total++; if (mem_cmd !== C_NONE) begin bad++; $display("FAIL rst_mem_cmd: got %0d want 0", mem_cmd); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_data !== '0) begin bad++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    endtask

    task automatic test_single_load();
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_addr = 64'h47; req_ptr = 3'd3;
        cmd_q.push_back('{C_LOAD, 64'h40, 64'h0});
        #1;
        total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL ld_accept: got %b want 1", req_rdy); end
        @(negedge clk); drive_idle(); mem_resp = 4'd5; #1;
        total++;
        if (cmd_q.size() == 0) begin bad++; $display("FAIL ld_cmd: no expected command, got cmd=%0d", mem_cmd); end
        else begin
            ec = cmd_q.pop_front();
            if (mem_cmd !== ec.cmd || mem_addr !== ec.addr || mem_data !== ec.data) begin
                bad++; $display("FAIL ld_cmd: got cmd=%0d addr=%h data=%h want cmd=%0d addr=%h data=%h",
                                mem_cmd, mem_addr, mem_data, ec.cmd, ec.addr, ec.data);
            end
        end
        @(negedge clk); drive_idle(); #1;
        total++; if (mem_cmd !== C_NONE || rsp_vld !== 1'b0) begin bad++; $display("FAIL ld_idle: got cmd=%0d rsp_vld=%b want 0/0", mem_cmd, rsp_vld); end
        @(negedge clk); drive_idle(); mem_tag = 4'd5; mem_rdata = 64'hABCD;
        rsp_q.push_back('{3'd3, 64'hABCD});
        #1;
        total++;
        if (rsp_q.size() == 0) begin bad++; $display("FAIL ld_rsp: no expected response, got vld=%b", rsp_vld); end
        else begin
            er = rsp_q.pop_front();
            if (rsp_vld !== 1'b1 || rsp_ptr !== er.ptr || rsp_data !== er.data) begin
                bad++; $display("FAIL ld_rsp: got vld=%b ptr=%0d data=%h want vld=1 ptr=%0d data=%h",
                                rsp_vld, rsp_ptr, rsp_data, er.ptr, er.data);
            end
        end
        @(negedge clk); drive_idle(); mem_tag = 4'd5; mem_rdata = 64'h1; #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL stale_tag: got rsp_vld=%b want 0", rsp_vld); end
    endtask

    task automatic test_out_of_order();
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_addr = 64'h100; req_ptr = 3'd1;
        cmd_q.push_back('{C_LOAD, 64'h100, 64'h0});
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_addr = 64'h108; req_ptr = 3'd4; mem_resp = 4'd2;
        cmd_q.push_back('{C_LOAD, 64'h108, 64'h0});
        #1;
        for (int n = 0; n < 2; n++) begin
            if (n == 1) begin @(negedge clk); drive_idle(); mem_resp = 4'd7; #1; end
            total++;
            if (cmd_q.size() == 0) begin bad++; $display("FAIL ooo_cmd%0d: no expected command", n); end
            else begin
                ec = cmd_q.pop_front();
                if (mem_cmd !== ec.cmd || mem_addr !== ec.addr) begin
                    bad++; $display("FAIL ooo_cmd%0d: got cmd=%0d addr=%h want cmd=%0d addr=%h",
                                    n, mem_cmd, mem_addr, ec.cmd, ec.addr);
                end
            end
        end
        rsp_q.push_back('{3'd4, 64'h77});
        rsp_q.push_back('{3'd1, 64'h22});
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); drive_idle();
            mem_tag = (n == 0) ? 4'd7 : 4'd2;
            mem_rdata = (n == 0) ? 64'h77 : 64'h22;
            #1;
            total++;
            if (rsp_q.size() == 0) begin bad++; $display("FAIL ooo_rsp%0d: no expected response", n); end
            else begin
                er = rsp_q.pop_front();
                if (rsp_vld !== 1'b1 || rsp_ptr !== er.ptr || rsp_data !== er.data) begin
                    bad++; $display("FAIL ooo_rsp%0d: got vld=%b ptr=%0d data=%h want vld=1 ptr=%0d data=%h",
                                    n, rsp_vld, rsp_ptr, rsp_data, er.ptr, er.data);
                end
            end
        end
    endtask

    task automatic test_late_store();
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_st = 1'b1; req_dat_rdy = 1'b0; req_addr = 64'h80; req_data = 64'hDEAD;
        cmd_q.push_back('{C_STORE, 64'h80, 64'h1234});
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_addr = 64'h200; req_ptr = 3'd2;
        cmd_q.push_back('{C_LOAD, 64'h200, 64'h0});
        #1;
        total++; if (mem_cmd !== C_NONE) begin bad++; $display("FAIL late_block0: got cmd=%0d want 0", mem_cmd); end
        @(negedge clk); drive_idle(); mem_resp = 4'd9; #1;
        total++; if (mem_cmd !== C_NONE) begin bad++; $display("FAIL late_block1: got cmd=%0d want 0", mem_cmd); end
        @(negedge clk); drive_idle(); wdat_vld = 1'b1; wdat_addr = 64'h80; wdat_data = 64'h1234; #1;
        total++; if (mem_cmd !== C_NONE) begin bad++; $display("FAIL late_block2: got cmd=%0d want 0", mem_cmd); end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); drive_idle(); mem_resp = (n == 0) ? 4'd1 : 4'd4; #1;
            total++;
            if (cmd_q.size() == 0) begin bad++; $display("FAIL late_cmd%0d: no expected command", n); end
            else begin
                ec = cmd_q.pop_front();
                if (mem_cmd !== ec.cmd || mem_addr !== ec.addr || mem_data !== ec.data) begin
                    bad++; $display("FAIL late_cmd%0d: got cmd=%0d addr=%h data=%h want cmd=%0d addr=%h data=%h",
                                    n, mem_cmd, mem_addr, mem_data, ec.cmd, ec.addr, ec.data);
                end
            end
        end
        @(negedge clk); drive_idle(); mem_tag = 4'd4; mem_rdata = 64'h99;
        rsp_q.push_back('{3'd2, 64'h99});
        #1;
        total++;
        if (rsp_q.size() == 0) begin bad++; $display("FAIL late_rsp: no expected response"); end
        else begin
            er = rsp_q.pop_front();
            if (rsp_vld !== 1'b1 || rsp_ptr !== er.ptr || rsp_data !== er.data) begin
                bad++; $display("FAIL late_rsp: got vld=%b ptr=%0d data=%h want vld=1 ptr=%0d data=%h",
                                rsp_vld, rsp_ptr, rsp_data, er.ptr, er.data);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            drive_idle();
            req_vld = 1'b1; req_addr = 64'h1000 + 64'(8 * i); req_ptr = 3'(i);
            #1;
            total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy%0d: got %b want 1", i, req_rdy); end
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); drive_idle(); #1;
            total++;
            if (req_rdy !== 1'b0 || mem_cmd !== C_LOAD || mem_addr !== 64'h1000) begin
                bad++; $display("FAIL full_hold%0d: got rdy=%b cmd=%0d addr=%h want 0/1/1000", n, req_rdy, mem_cmd, mem_addr);
            end
        end
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_addr = 64'h2000; req_ptr = 3'd7; mem_resp = 4'd3; #1;
        total++;
        if (req_rdy !== 1'b1 || mem_cmd !== C_LOAD || mem_addr !== 64'h1000) begin
            bad++; $display("FAIL full_swap: got rdy=%b cmd=%0d addr=%h want 1/1/1000", req_rdy, mem_cmd, mem_addr);
        end
        @(negedge clk); drive_idle(); #1;
        total++;
        if (req_rdy !== 1'b0 || mem_cmd !== C_LOAD || mem_addr !== 64'h1008) begin
            bad++; $display("FAIL full_after: got rdy=%b cmd=%0d addr=%h want 0/1/1008", req_rdy, mem_cmd, mem_addr);
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            drive_idle();
            req_vld = 1'b1; req_addr = 64'h300 + 64'(8 * i); req_ptr = 3'(i);
            mem_resp = (i == 1) ? 4'd2 : (i == 2) ? 4'd6 : 4'd0;
            #1;
            if (i == 1) begin
                total++; if (mem_cmd !== C_LOAD || mem_addr !== 64'h300) begin bad++; $display("FAIL flush_pre: got cmd=%0d addr=%h want 1/300", mem_cmd, mem_addr); end
            end
        end
        @(negedge clk); drive_idle(); rst = 1'b1;
        @(negedge clk); drive_idle(); rst = 1'b0; mem_tag = 4'd2; mem_rdata = 64'h5; #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL flush_rsp2: got rsp_vld=%b want 0", rsp_vld); end
        total++; if (mem_cmd !== C_NONE) begin bad++; $display("FAIL flush_cmd: got cmd=%0d want 0", mem_cmd); end
        total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL flush_rdy: got %b want 1", req_rdy); end
        @(negedge clk); drive_idle(); mem_tag = 4'd6; mem_rdata = 64'h6; #1;
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL flush_rsp6: got rsp_vld=%b want 0", rsp_vld); end
    endtask

    // Ready store followed by a load to the same block.
    task automatic test_store_load();
        do_reset();
        req_vld = 1'b1; req_st = 1'b1; req_dat_rdy = 1'b1; req_addr = 64'hC0; req_data = 64'h55;
        cmd_q.push_back('{C_STORE, 64'hC0, 64'h55});
        @(negedge clk); drive_idle();
        req_vld = 1'b1; req_addr = 64'hC0; req_ptr = 3'd6;
`ifndef DMEM_LD_FWD_EN
        cmd_q.push_back('{C_LOAD, 64'hC0, 64'h0});
`endif
        #1;
        total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL sl_rdy: got %b want 1", req_rdy); end
        total++;
        if (cmd_q.size() == 0) begin bad++; $display("FAIL sl_store: no expected command"); end
        else begin
            ec = cmd_q.pop_front();
            if (mem_cmd !== ec.cmd || mem_addr !== ec.addr || mem_data !== ec.data) begin
                bad++; $display("FAIL sl_store: got cmd=%0d addr=%h data=%h want cmd=%0d addr=%h data=%h",
                                mem_cmd, mem_addr, mem_data, ec.cmd, ec.addr, ec.data);
            end
        end
        @(negedge clk); drive_idle(); #1;
`ifdef DMEM_LD_FWD_EN
        rsp_q.push_back('{3'd6, 64'h55});
        total++;
        if (rsp_q.size() == 0) begin bad++; $display("FAIL fwd_rsp: no expected response"); end
        else begin
            er = rsp_q.pop_front();
            if (rsp_vld !== 1'b1 || rsp_ptr !== er.ptr || rsp_data !== er.data) begin
                bad++; $display("FAIL fwd_rsp: got vld=%b ptr=%0d data=%h want vld=1 ptr=%0d data=%h",
                                rsp_vld, rsp_ptr, rsp_data, er.ptr, er.data);
            end
        end
        total++; if (req_rdy !== 1'b0) begin bad++; $display("FAIL fwd_busy: got req_rdy=%b want 0", req_rdy); end
`else
        total++; if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin bad++; $display("FAIL sl_quiet: got rsp_vld=%b rdy=%b want 0/1", rsp_vld, req_rdy); end
`endif
        @(negedge clk); drive_idle(); mem_resp = 4'd1; #1;
        total++; if (mem_cmd !== C_STORE) begin bad++; $display("FAIL sl_store_acc: got cmd=%0d want 2", mem_cmd); end
        total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL sl_rsp_off: got rsp_vld=%b want 0", rsp_vld); end
        @(negedge clk); drive_idle(); mem_resp = 4'd5; #1;
`ifdef DMEM_LD_FWD_EN
        total++; if (mem_cmd !== C_NONE) begin bad++; $display("FAIL fwd_no_load: got cmd=%0d want 0", mem_cmd); end
`else
        total++;
        if (cmd_q.size() == 0) begin bad++; $display("FAIL sl_load: no expected command"); end
        else begin
            ec = cmd_q.pop_front();
            if (mem_cmd !== ec.cmd || mem_addr !== ec.addr) begin
                bad++; $display("FAIL sl_load: got cmd=%0d addr=%h want cmd=%0d addr=%h", mem_cmd, mem_addr, ec.cmd, ec.addr);
            end
        end
        @(negedge clk); drive_idle(); mem_tag = 4'd5; mem_rdata = 64'h55;
        rsp_q.push_back('{3'd6, 64'h55});
        #1;
        total++;
        if (rsp_q.size() == 0) begin bad++; $display("FAIL sl_rsp: no expected response"); end
        else begin
            er = rsp_q.pop_front();
            if (rsp_vld !== 1'b1 || rsp_ptr !== er.ptr || rsp_data !== er.data) begin
                bad++; $display("FAIL sl_rsp: got vld=%b ptr=%0d data=%h want vld=1 ptr=%0d data=%h",
                                rsp_vld, rsp_ptr, rsp_data, er.ptr, er.data);
            end
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_load();
        test_out_of_order();
        test_late_store();
        test_full();
        test_reset_flush();
        test_store_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
